// File: rtl/cdb_multi_arbiter.sv
// cdb_multi_arbiter: grants up to K of N requesters onto K common-data-bus
// lanes each cycle. Requesters denied for AGE_LIMIT cycles are starved and
// jump ahead of everyone else. Within each class, order rotates from ptr.
// Outputs are combinational from request and the registered ptr/age state,
// and are held at zero while reset is high.
module cdb_multi_arbiter #(
  parameter int N           = 4,
  parameter int K           = 2,
  parameter int ROUND_ROBIN = 1,
  parameter int AGE_LIMIT   = 8,
  localparam int IDXW       = (N > 1) ? $clog2(N) : 1,
  localparam int AW         = $clog2(AGE_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      request,
  output logic [N-1:0]      grant,
  output logic [K-1:0]      lane_valid,
  output logic [K*IDXW-1:0] lane_sel
);

  logic [IDXW-1:0]        ptr_s;
  logic [N-1:0][AW-1:0]   age_q;
  logic [N-1:0][AW-1:0]   age_d;
  logic [N-1:0]           starved_s;

  // A requester is starved once its denied-cycle count reaches the limit
  always_comb begin
    for (int i = 0; i < N; i++) begin
      starved_s[i] = (age_q[i] == AW'(AGE_LIMIT));
    end
  end

  // Two passes from ptr (starved class, then the rest); fill lanes in that order
  always_comb begin
    int              cnt;
    int              pos;
    logic [IDXW-1:0] idx;
    logic            take;
    grant      = {N{1'b0}};
    lane_valid = {K{1'b0}};
    lane_sel   = {(K*IDXW){1'b0}};
    cnt        = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < N; j++) begin
        pos  = int'(ptr_s) + j;
        pos  = (pos >= N) ? (pos - N) : pos;
        idx  = IDXW'(pos);
        take = request[idx] && (starved_s[idx] == (pass == 0)) &&
               (cnt < K) && !reset;
        grant[idx] = grant[idx] | take;
        for (int k = 0; k < K; k++) begin
          if (take && (k == cnt)) begin
            lane_valid[k]               = 1'b1;
            lane_sel[k*IDXW +: IDXW]    = idx;
          end else begin
            lane_valid[k]               = lane_valid[k];
            lane_sel[k*IDXW +: IDXW]    = lane_sel[k*IDXW +: IDXW];
          end
        end
        cnt = cnt + (take ? 1 : 0);
      end
    end
  end

  // Age: clear on grant or idle, otherwise count denied cycles up to the limit
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (grant[i] || !request[i]) begin
        age_d[i] = {AW{1'b0}};
      end else if (starved_s[i]) begin
        age_d[i] = age_q[i];
      end else begin
        age_d[i] = age_q[i] + AW'(1);
      end
    end
  end

  // Age counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age_q <= {(N*AW){1'b0}};
    end else begin
      age_q <= age_d;
    end
  end

  generate
    if (ROUND_ROBIN != 0) begin : g_rr
      logic [IDXW-1:0] ptr_q;
      logic [IDXW-1:0] ptr_d;
      logic [IDXW-1:0] last_s;

      // Requester on the highest-numbered valid lane is the last one granted
      always_comb begin
        last_s = {IDXW{1'b0}};
        for (int k = 0; k < K; k++) begin
          if (lane_valid[k]) begin
            last_s = lane_sel[k*IDXW +: IDXW];
          end else begin
            last_s = last_s;
          end
        end
      end

      // Pointer moves just past the last grant, wrapping modulo N; holds when idle
      always_comb begin
        if (|grant) begin
          ptr_d = (last_s == IDXW'(N - 1)) ? {IDXW{1'b0}} : (last_s + IDXW'(1));
        end else begin
          ptr_d = ptr_q;
        end
      end

      // Rotating priority pointer register
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          ptr_q <= {IDXW{1'b0}};
        end else begin
          ptr_q <= ptr_d;
        end
      end

      assign ptr_s = ptr_q;
    end else begin : g_fixed
      assign ptr_s = {IDXW{1'b0}};
    end
  endgenerate

endmodule

// File: tb/tb_cdb_multi_arbiter.sv
// Bench for cdb_multi_arbiter: two instances (default rotating N=4/K=2/AGE=8
// and fixed-priority N=4/K=1/AGE=3) checked every cycle against a queue-based
// priority model, plus hand-computed directed expectations.
module tb_cdb_multi_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic [1:0] lv_a;
  logic [0:0] lv_b;
  logic [3:0] ls_a;
  logic [1:0] ls_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  int ptr_a = 0;
  int age_a[4] = '{0, 0, 0, 0};
  int age_b[4] = '{0, 0, 0, 0};

  cdb_multi_arbiter #(.N(4), .K(2), .ROUND_ROBIN(1), .AGE_LIMIT(8)) dut_a (
    .clk(clk), .reset(reset), .request(req_a),
    .grant(grant_a), .lane_valid(lv_a), .lane_sel(ls_a)
  );

  cdb_multi_arbiter #(.N(4), .K(1), .ROUND_ROBIN(0), .AGE_LIMIT(3)) dut_b (
    .clk(clk), .reset(reset), .request(req_b),
    .grant(grant_b), .lane_valid(lv_b), .lane_sel(ls_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Build the priority list (starved first, then others, each from ptr) and take the first k
  function automatic void arb_model(input logic [3:0] req, input int ptr, input int age[4],
                                    input int k, input int al,
                                    output logic [3:0] g, output logic [1:0] lv,
                                    output logic [3:0] ls, output int last);
    int order[$];
    int idx;
    g = 4'b0000; lv = 2'b00; ls = 4'b0000; last = -1;
    for (int cls = 0; cls < 2; cls++) begin
      for (int j = 0; j < 4; j++) begin
        idx = (ptr + j) % 4;
        if (req[idx] && ((age[idx] == al) == (cls == 0))) order.push_back(idx);
      end
    end
    for (int l = 0; l < k && l < order.size(); l++) begin
      g[order[l]] = 1'b1;
      lv[l] = 1'b1;
      ls[l*2 +: 2] = 2'(order[l]);
      last = order[l];
    end
  endfunction

  // Advance model state on each clock edge; clear it on reset
  always @(posedge clk or posedge reset) begin : model_update
    logic [3:0] g;
    logic [1:0] lv;
    logic [3:0] ls;
    int last;
    if (reset) begin
      ptr_a <= 0;
      for (int i = 0; i < 4; i++) begin
        age_a[i] <= 0;
        age_b[i] <= 0;
      end
    end else begin
      arb_model(req_a, ptr_a, age_a, 2, 8, g, lv, ls, last);
      if (g != 4'b0000) ptr_a <= (last + 1) % 4;
      for (int i = 0; i < 4; i++)
        age_a[i] <= (g[i] || !req_a[i]) ? 0 : ((age_a[i] < 8) ? age_a[i] + 1 : 8);
      arb_model(req_b, 0, age_b, 1, 3, g, lv, ls, last);
      for (int i = 0; i < 4; i++)
        age_b[i] <= (g[i] || !req_b[i]) ? 0 : ((age_b[i] < 3) ? age_b[i] + 1 : 3);
    end
  end

  // Compare both DUTs with the model on every falling edge
  always @(negedge clk) begin : compare
    logic [3:0] g;
    logic [1:0] lv;
    logic [3:0] ls;
    int last;
    if (reset) begin
      check("rst_grant_a", grant_a, 32'd0);
      check("rst_lv_a", lv_a, 32'd0);
      check("rst_ls_a", ls_a, 32'd0);
      check("rst_grant_b", grant_b, 32'd0);
    end else begin
      arb_model(req_a, ptr_a, age_a, 2, 8, g, lv, ls, last);
      check("cmp_grant_a", grant_a, g);
      check("cmp_lv_a", lv_a, lv);
      check("cmp_ls_a", ls_a, ls);
      arb_model(req_b, 0, age_b, 1, 3, g, lv, ls, last);
      check("cmp_grant_b", grant_b, g);
      check("cmp_lv_b", lv_b, lv[0:0]);
      check("cmp_ls_b", ls_b, ls[1:0]);
    end
  end

  initial begin
    reset = 1'b1;
    req_a = 4'b1111;
    req_b = 4'b1111;
    repeat (2) @(negedge clk);
    check("lit_rst_hold_grant_a", grant_a, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    // Cycles 0..5 from reset, request all-ones held
    @(negedge clk);
    check("lit_a_c0_grant", grant_a, 32'b0011);
    check("lit_a_c0_sel", ls_a, 32'b0100);
    check("lit_a_c0_lv", lv_a, 32'b11);
    check("lit_b_c0_grant", grant_b, 32'b0001);
    @(negedge clk);
    check("lit_a_c1_grant", grant_a, 32'b1100);
    check("lit_a_c1_sel", ls_a, 32'b1110);
    check("lit_b_c1_grant", grant_b, 32'b0001);
    @(negedge clk);
    check("lit_a_c2_grant", grant_a, 32'b0011);
    check("lit_b_c2_grant", grant_b, 32'b0001);
    @(negedge clk);
    check("lit_b_c3_grant", grant_b, 32'b0010);
    check("lit_b_c3_sel", ls_b, 32'd1);
    @(negedge clk);
    check("lit_b_c4_grant", grant_b, 32'b0100);
    @(negedge clk);
    check("lit_b_c5_grant", grant_b, 32'b1000);
    @(negedge clk);
    // Cycle 7: ptr_a is 2; pulse reset between edges
    @(posedge clk); #1;
    check("lit_a_prepulse_grant", grant_a, 32'b1100);
    req_b = 4'b1001;
    reset = 1'b1;
    #2;
    check("lit_pulse_grant_a", grant_a, 32'h0);
    check("lit_pulse_lv_a", lv_a, 32'h0);
    check("lit_pulse_sel_a", ls_a, 32'h0);
    reset = 1'b0;
    #1;
    check("lit_postpulse_grant_a", grant_a, 32'b0011);
    check("lit_postpulse_sel_a", ls_a, 32'b0100);
    // Requester 3 on dut_b: denied twice, drops out once, re-requests
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_b = 4'b0001;
    @(posedge clk); #1;
    req_b = 4'b1001;
    @(negedge clk);
    check("lit_b_restart_d0", grant_b, 32'b0001);
    @(negedge clk);
    check("lit_b_restart_d1", grant_b, 32'b0001);
    @(negedge clk);
    check("lit_b_restart_d2", grant_b, 32'b0001);
    @(negedge clk);
    check("lit_b_restart_starved", grant_b, 32'b1000);
    // Single request from ptr 0, then confirm ptr moved to 3
    @(posedge clk); #1;
    req_a = 4'b0100;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(negedge clk);
    check("lit_a_single_grant", grant_a, 32'b0100);
    check("lit_a_single_lv", lv_a, 32'b01);
    check("lit_a_single_sel", ls_a, 32'b0010);
    @(posedge clk); #1;
    req_a = 4'b1111;
    @(negedge clk);
    check("lit_a_ptr3_grant", grant_a, 32'b1001);
    check("lit_a_ptr3_sel", ls_a, 32'b0011);
    @(posedge clk); #1;
    req_a = 4'b0010;
    @(negedge clk);
    check("lit_a_ptr1_grant", grant_a, 32'b0010);
    @(posedge clk); #1;
    req_a = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("lit_a_idle_grant", grant_a, 32'h0);
      check("lit_a_idle_lv", lv_a, 32'h0);
      check("lit_a_idle_sel", ls_a, 32'h0);
      @(posedge clk); #1;
    end
    req_a = 4'b1111;
    @(negedge clk);
    check("lit_a_ptr_held_grant", grant_a, 32'b1100);
    check("lit_a_ptr_held_sel", ls_a, 32'b1110);
    // Mixed traffic, checked by the model every cycle
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      req_a = 4'($urandom);
      req_b = 4'($urandom) | 4'b1000;
      if (c == 200) begin
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
